lane_halver: RTL

//   Inverse of the ALU lane-duplication path. Each accepted V-lane input vector is reduced pairwise,

---
 rtl/lane_halver_if.sv | 27 ++
 rtl/lane_halver.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lane_halver_if.sv
// Valid/ready bus for the lane halver: V-lane input beats in, packed V-lane vectors out.
interface lane_halver_if #(
    parameter int N = 16,
    parameter int V = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [V-1:0][N-1:0]   in_vec;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [V-1:0][N-1:0]   out_vec;
    logic                  out_half;

    // Producer/consumer side (ALU result source and writeback sink).
    modport master (
        output in_valid, in_mode, in_vec, flush, out_ready,
        input  in_ready, out_valid, out_vec, out_half
    );

    // The halver itself.
    modport slave (
        input  in_valid, in_mode, in_vec, flush, out_ready,
        output in_ready, out_valid, out_vec, out_half
    );
endinterface

// File: rtl/lane_halver.sv
// Lane halver: reduces each V-lane beat pairwise to V/2 lanes and packs two
// reduced beats into one V-lane output vector (1 output per 2 inputs).

// One lane pair -> one lane, mode-selected.
module lane_pair_reduce #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   mode,
    output logic [N-1:0] r
);
    logic [N-1:0] avg;

    // floor((a+b)/2) without an N+1-bit sum: halve each, add back the shared carry bit.
    assign avg = (a >> 1) + (b >> 1) + {{(N-1){1'b0}}, a[0] & b[0]};

    // Select the reduction for this pair.
    always_comb begin
        r = a;
        case (mode)
            2'b00:   r = a;
            2'b01:   r = b;
            2'b10:   r = avg;
            default: r = (a > b) ? a : b;
        endcase
    end
endmodule

module lane_halver #(
    parameter int N = 16,
    parameter int V = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    lane_halver_if.slave    bus
);
    localparam int H = V / 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LO_HELD = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t              state;
    logic                valid_q;
    logic                half_q;
    logic [V-1:0][N-1:0] vec_q;
    logic [H-1:0][N-1:0] red;
    logic                in_ready;
    logic                accept;

    // Per-pair reducers.
    for (genvar k = 0; k < H; k++) begin : g_pair
        lane_pair_reduce #(.N(N)) u_red (
            .a    (bus.in_vec[2*k]),
            .b    (bus.in_vec[2*k+1]),
            .mode (bus.in_mode),
            .r    (red[k])
        );
    end

    // In FULL a beat may only enter while the held vector leaves the same cycle.
    assign in_ready = (state != FULL) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_half  = half_q;
    assign bus.out_vec   = vec_q;

    // Packing FSM; vec_q doubles as the output register, so it only moves on
    // fills and never while a FULL vector waits for its handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            half_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        vec_q[H-1:0] <= red;
                        vec_q[V-1:H] <= '0;
                        state        <= LO_HELD;
                    end
                end
                LO_HELD: begin
                    if (accept) begin
                        // A real second beat beats a coincident flush.
                        vec_q[V-1:H] <= red;
                        half_q       <= 1'b0;
                        valid_q      <= 1'b1;
                        state        <= FULL;
                    end else if (bus.flush) begin
                        // Upper half was already zeroed on entry to LO_HELD.
                        half_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            vec_q[H-1:0] <= red;
                            vec_q[V-1:H] <= '0;
                            state        <= LO_HELD;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
